// File: rtl/led_pkg.sv
// Shared constants and types for the LED afterglow display stage.
package led_pkg;

  // Brightness resolution: levels 0..BRIGHT_MAX, PWM period BRIGHT_MAX cycles.
  localparam int BRIGHT_W   = 4;
  localparam int BRIGHT_MAX = (1 << BRIGHT_W) - 1;

  // Default prescale: clock cycles per one-level decay step (must be >= 2).
  localparam int DECAY_DIV_DEFAULT = 250000;

  typedef logic [BRIGHT_W-1:0] level_t;

endpackage

// File: rtl/led_trail_cell.sv
// One LED: brightness level register, PWM comparator and registered drive.
module led_trail_cell
  import led_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   enable,
  input  logic   set,
  input  logic   decay_tick,
  input  level_t pwm_cnt,
  output logic   led
);

  level_t level;

  // Level update (set beats decay, floor at 0) and PWM drive from the held level.
  // NOTE: non-blocking assignments so the comparator sees the level from before
  // this edge, which gives the two-edge set-to-output latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level <= '0;
      led   <= 1'b0;
    end else if (enable) begin
      led <= (level > pwm_cnt);
      if (set) begin
        level <= level_t'(BRIGHT_MAX);
      end else if (decay_tick && (level != '0)) begin
        level <= level - level_t'(1);
      end
    end else begin
      led <= 1'b0;
    end
  end

endmodule

// File: rtl/led_trail_pwm.sv
// Afterglow LED driver: shared decay prescaler and PWM counter feeding one
// led_trail_cell per LED.
module led_trail_pwm
  import led_pkg::*;
#(
  parameter int N_LEDS    = 10,
  parameter int DECAY_DIV = DECAY_DIV_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_LEDS-1:0] pattern,
  output logic [N_LEDS-1:0] led_out
);

  localparam int              DIV_W    = $clog2(DECAY_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);
  localparam level_t          PWM_LAST = level_t'(BRIGHT_MAX - 1);

  logic [DIV_W-1:0] div_cnt;
  level_t           pwm_cnt;
  logic             decay_tick;

  assign decay_tick = (div_cnt == DIV_LAST);

  // Free-running prescaler and PWM phase; both freeze while disabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else if (enable) begin
      div_cnt <= decay_tick ? '0 : div_cnt + DIV_W'(1);
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + level_t'(1);
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_cell
    led_trail_cell u_cell (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .set        (pattern[i]),
      .decay_tick (decay_tick),
      .pwm_cnt    (pwm_cnt),
      .led        (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: two instances (fast and slow decay) run side by
// side against an arithmetic reference model, plus scenario-specific checks.
module tb_led_trail_pwm;

  localparam int N      = 10;
  localparam int DIV_A  = 4;
  localparam int DIV_B  = 1000;
  localparam int PERIOD = 15;
  localparam int LMAX   = 15;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] pattern;
  logic [N-1:0] led_a;
  logic [N-1:0] led_b;

  int compared   = 0;
  int mismatched = 0;

  // Model: brightness per LED and a count of enabled edges since reset.
  // Prescaler and PWM phase follow from that count by modular arithmetic.
  int           en_cycles[2];
  int           lvl[2][N];
  logic [N-1:0] exp_led[2];

  always #5 clock = ~clock;

  led_trail_pwm #(.N_LEDS(N), .DECAY_DIV(DIV_A)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .pattern(pattern), .led_out(led_a)
  );

  led_trail_pwm #(.N_LEDS(N), .DECAY_DIV(DIV_B)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .pattern(pattern), .led_out(led_b)
  );

  function automatic int div_of(input int d);
    return (d == 0) ? DIV_A : DIV_B;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      en_cycles[d] = 0;
      exp_led[d]   = '0;
      for (int i = 0; i < N; i++) lvl[d][i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (enable) begin
        bit tick;
        int phase;
        tick  = (en_cycles[d] % div_of(d)) == div_of(d) - 1;
        phase = en_cycles[d] % PERIOD;
        for (int i = 0; i < N; i++) begin
          exp_led[d][i] = (lvl[d][i] > phase);
          if (pattern[i])                 lvl[d][i] = LMAX;
          else if (tick && lvl[d][i] > 0) lvl[d][i] = lvl[d][i] - 1;
        end
        en_cycles[d]++;
      end else begin
        exp_led[d] = '0;
      end
    end
  endtask

  // One clock: advance the model, then compare both DUTs 1 time unit later.
  task automatic step();
    @(posedge clock);
    if (!reset) model_edge();
    #1;
    compared++;
    if (led_a !== exp_led[0]) begin
      mismatched++;
      $display("FAIL cycle_div4 t=%0t led_out=%b expected=%b", $time, led_a, exp_led[0]);
    end
    compared++;
    if (led_b !== exp_led[1]) begin
      mismatched++;
      $display("FAIL cycle_div1000 t=%0t led_out=%b expected=%b", $time, led_b, exp_led[1]);
    end
  endtask

  task automatic bound_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s wait bound expired t=%0t", name, $time);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    compared++;
    if ((led_a !== '0) || (led_b !== '0)) begin
      mismatched++;
      $display("FAIL reset_async led_a=%b led_b=%b expected=0", led_a, led_b);
    end
    model_reset();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int highs;
    enable  = 1'b1;
    pattern = 10'b0000110000;
    repeat (20) step();
    compared++;
    if (led_a[5:4] !== 2'b11) begin
      mismatched++;
      $display("FAIL reset_pre_lit led_a[5:4]=%b expected=11", led_a[5:4]);
    end
    #2;
    do_reset();
    pattern = '0;
    highs = 0;
    repeat (20) begin
      step();
      if ((led_a | led_b) != '0) highs++;
    end
    compared++;
    if (highs != 0) begin
      mismatched++;
      $display("FAIL reset_stay_dark lit_cycles=%0d expected=0", highs);
    end
  endtask

  task automatic test_single_pulse();
    int late_highs;
    do_reset();
    enable  = 1'b1;
    pattern = 10'b0000000001;
    step();
    pattern = '0;
    late_highs = 0;
    for (int k = 1; k < 90; k++) begin
      step();
      if (k == 1) begin
        compared++;
        if (led_a[0] !== 1'b1) begin
          mismatched++;
          $display("FAIL pulse_latency led_out[0]=%b expected=1", led_a[0]);
        end
      end
      if (k >= 60 && led_a[0]) late_highs++;
    end
    compared++;
    if (late_highs != 0) begin
      mismatched++;
      $display("FAIL pulse_faded_out lit_cycles=%0d expected=0", late_highs);
    end
  endtask

  task automatic test_hold_duty();
    int highs;
    int guard;
    do_reset();
    enable  = 1'b1;
    pattern = 10'b0000010000;
    repeat (15) step();
    highs = 0;
    repeat (PERIOD) begin
      step();
      if (led_b[4]) highs++;
    end
    compared++;
    if (highs != 15) begin
      mismatched++;
      $display("FAIL duty_full high_cycles=%0d expected=15", highs);
    end
    pattern = '0;
    guard = 0;
    while (en_cycles[1] < DIV_B && guard < 2 * DIV_B) begin
      step();
      guard++;
    end
    if (guard >= 2 * DIV_B) bound_fail("duty_first_tick");
    highs = 0;
    repeat (PERIOD) begin
      step();
      if (led_b[4]) highs++;
    end
    compared++;
    if (highs != 14) begin
      mismatched++;
      $display("FAIL duty_after_tick high_cycles=%0d expected=14", highs);
    end
  endtask

  task automatic test_collision();
    int guard;
    do_reset();
    enable  = 1'b1;
    pattern = 10'b0000000100;
    step();
    pattern = '0;
    guard = 0;
    while (lvl[0][2] != 7 && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) bound_fail("collision_reach_7");
    guard = 0;
    while ((en_cycles[0] % DIV_A) != DIV_A - 1 && guard < 10) begin
      step();
      guard++;
    end
    if (guard >= 10) bound_fail("collision_find_tick");
    pattern = 10'b0000000100;
    step();
    pattern = '0;
    step();
    // Level 15 drives 1 at every PWM phase; a decayed 6 would not at this one.
    compared++;
    if (led_a[2] !== 1'b1) begin
      mismatched++;
      $display("FAIL collision_set_wins led_out[2]=%b expected=1", led_a[2]);
    end
    repeat (10) step();
  endtask

  task automatic test_enable_freeze();
    int guard;
    int highs;
    do_reset();
    enable  = 1'b1;
    pattern = 10'b1000000000;
    step();
    pattern = '0;
    guard = 0;
    while (lvl[0][9] != 9 && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) bound_fail("freeze_reach_9");
    enable = 1'b0;
    pattern = 10'b1111111111;
    step();
    compared++;
    if ((led_a | led_b) !== '0) begin
      mismatched++;
      $display("FAIL freeze_dark_1edge led_a=%b led_b=%b expected=0", led_a, led_b);
    end
    highs = 0;
    repeat (19) begin
      step();
      if ((led_a | led_b) != '0) highs++;
    end
    compared++;
    if (highs != 0) begin
      mismatched++;
      $display("FAIL freeze_dark lit_cycles=%0d expected=0", highs);
    end
    pattern = '0;
    enable  = 1'b1;
    repeat (45) step();
  endtask

  task automatic test_upstream();
    logic [N-1:0] seq [5];
    seq[0] = 10'b0000110000;
    seq[1] = 10'b0001001000;
    seq[2] = 10'b0010000100;
    seq[3] = 10'b0100000010;
    seq[4] = 10'b1000000001;
    do_reset();
    enable = 1'b1;
    for (int s = 0; s < 9; s++) begin
      pattern = seq[(s < 5) ? s : 8 - s];
      repeat (8) step();
      compared++;
      if ((led_a & pattern) !== pattern) begin
        mismatched++;
        $display("FAIL upstream_active step=%0d led_out=%b expected_on=%b", s, led_a, pattern);
      end
    end
    pattern = '0;
    repeat (70) step();
    compared++;
    if (led_a !== '0) begin
      mismatched++;
      $display("FAIL upstream_decayed led_out=%b expected=0", led_a);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      pattern = N'($urandom & $urandom & $urandom);
      enable  = ($urandom_range(0, 9) != 0);
      if (c == 300) begin
        #2;
        do_reset();
      end
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    pattern = '0;
    model_reset();
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_single_pulse();
    test_hold_duty();
    test_collision();
    test_enable_freeze();
    test_upstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/led_trail_pwm.md
# led_trail_pwm

Downstream display stage for the bouncing LED pattern generator. It consumes the 10-bit `pattern` word each clock and drives the physical LEDs with a fading "afterglow" trail. An LED whose pattern bit is set lights at full brightness, then dims linearly through PWM once the bit clears. It sits between the pattern generator and the board LED pins, on the same clock.

## Interface
- `N_LEDS`, default 10: width of the pattern and LED vectors.
- `BRIGHT_W`, default 4: brightness level width. `BRIGHT_MAX` = 2^BRIGHT_W − 1 = 15.
- `DECAY_DIV`, default 250000: clock cycles per one-level decay step. Must be ≥ 2.
- `clock` input, 1 bit: single system clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `enable` input, 1 bit: run/freeze control.
- `pattern` input, N_LEDS bits: pattern from the upstream generator, sampled every edge.
- `led_out` output, N_LEDS bits: registered PWM drive, 1 = LED on.

## Operation
- Per-LED state is `level[i]`, BRIGHT_W bits, unsigned.
- Prescaler `div_cnt` counts 0..DECAY_DIV−1 and wraps to 0.
  - `decay_tick` = (div_cnt == DECAY_DIV−1), combinational.
- PWM counter `pwm_cnt`, BRIGHT_W bits, counts 0..BRIGHT_MAX−1 and wraps to 0. The PWM period is 15 cycles.
- Level update at each edge while `enable` = 1, for each i:
  - If pattern[i] = 1: level[i] ← BRIGHT_MAX.
  - Else if decay_tick and level[i] ≠ 0: level[i] ← level[i] − 1.
  - Otherwise: level holds. Level saturates at 0 and never wraps.
- Simultaneous set and decay on the same edge: set wins, level = BRIGHT_MAX.
- Output at each edge while `enable` = 1: led_out[i] ← (level[i] > pwm_cnt).
  - Duty = level/15.
  - Level 15 gives a constant 1; level 0 gives a constant 0.
- While `enable` = 0:
  - `div_cnt`, `pwm_cnt` and `level` all hold.
  - `pattern` is ignored.
  - led_out ← 0 at the next edge.
  - On re-enable, operation resumes from the held state.
- Reset, asynchronous and valid mid-operation: all `level` = 0, `div_cnt` = 0, `pwm_cnt` = 0, `led_out` = 0, taking effect immediately. The first decay_tick after reset release comes at the edge where div_cnt reaches DECAY_DIV−1.

## Timing
- pattern[i] = 1 before edge k → level[i] = 15 after edge k → led_out[i] = 1 after edge k+1. Set-to-output latency is 2 edges.
- Decay step to visible output change: 1 edge after the level changes.
- Full fade 15 → 0 takes 15 × DECAY_DIV cycles after the bit clears.
- No handshake. The upstream pattern may change on any edge; each edge's value is taken as-is.

## Structure
- Shared package `led_pkg`: `BRIGHT_W`, `BRIGHT_MAX`, a level typedef `level_t`, and the default `DECAY_DIV`.
- Sub-module `led_trail_cell` holds one LED's level register plus its PWM comparator and output flop. Inputs: set, decay_tick, pwm_cnt, enable.
- The top level generates N_LEDS cells and owns the shared prescaler and PWM counter.

## Test plan
Use DECAY_DIV = 4 unless stated otherwise.
- **Reset:** hold pattern = 10'b0000110000, then assert reset mid-run → led_out = 0 in the same cycle. After release with pattern = 0, led_out stays 0.
- **Single pulse on bit 0:** one cycle of pattern = 10'b0000000001 → level[0] = 15. It decrements once every 4 cycles and reaches 0 after 60 cycles. led_out[0] = 0 from then on, and never wraps back to 15.
- **Hold and duty (DECAY_DIV = 1000):**
  - Hold bit 4 high → led_out[4] is 1 on every cycle of a 15-cycle PWM window.
  - Release bit 4 and let the first tick occur → exactly 14 high cycles per 15-cycle period.
- **Set vs. tick collision:** level[2] = 7, then assert pattern[2] on the decay_tick edge → level[2] = 15, not 6.
- **Enable freeze:** level[9] = 9, drop enable for 20 cycles → led_out = 0 after 1 edge and level[9] stays 9. Restore enable → decay resumes from 9.
- **Upstream sequence:** drive 0000110000, 0001001000, 0010000100, 0100000010, 1000000001 and back, one per 8 cycles → bits most recently set show the highest duty. Inactive bits decay monotonically to 0.
